// File: rtl/layerio_instruc_issuer_if.sv
// Bundle of signals between the layerio instruction issuer and its environment:
// the descriptor handshake, the instruction FIFO write port, the credit return
// and the status outputs. The master side is the issuer; the slave side is the
// environment that offers descriptors, owns the FIFO and returns credits.
interface layerio_instruc_issuer_if #(
    parameter int DIGIT_WIDTH  = 16,
    parameter int TOTAL_DIGITS = 8,
    parameter int MAX_INFLIGHT = 2
);
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    logic                                  desc_valid;
    logic                                  desc_ready;
    logic [TOTAL_DIGITS*DIGIT_WIDTH-1:0]   desc_sizes;
    logic [TOTAL_DIGITS*DIGIT_WIDTH-1:0]   desc_strides;
    logic [DIGIT_WIDTH-1:0]                desc_offset;
    logic                                  instruc_wrreq;
    logic [DIGIT_WIDTH-1:0]                instruc_d;
    logic                                  instruc_full;
    logic                                  wrote_layerio_layer;
    logic                                  issued_layer;
    logic [INF_W-1:0]                      inflight;
    logic                                  underflow_err;
    logic                                  desc_err;

    modport master (
        input  desc_valid, desc_sizes, desc_strides, desc_offset,
               instruc_full, wrote_layerio_layer,
        output desc_ready, instruc_wrreq, instruc_d, issued_layer,
               inflight, underflow_err, desc_err
    );

    modport slave (
        output desc_valid, desc_sizes, desc_strides, desc_offset,
               instruc_full, wrote_layerio_layer,
        input  desc_ready, instruc_wrreq, instruc_d, issued_layer,
               inflight, underflow_err, desc_err
    );
endinterface

// File: rtl/layerio_instruc_issuer.sv
// Producer end of the layerio tiler instruction FIFO. One layer descriptor is
// accepted per handshake and written into the FIFO one field per write:
// sizes[0..], strides[0..], then offset. The number of layers queued ahead of
// the writer is bounded by MAX_INFLIGHT using credits from wrote_layerio_layer.
// Optional feature: define LAYERIO_INSTRUC_VALIDATE_EN to drop descriptors that
// carry a zero size digit (desc_err pulses instead of sending the layer).
module layerio_instruc_issuer #(
    parameter int DIGIT_WIDTH  = 16,
    parameter int TOTAL_DIGITS = 8,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    layerio_instruc_issuer_if.master bus
);
    localparam int TOTAL_PARAMS = 2 * TOTAL_DIGITS + 1;
    localparam int IDX_W        = $clog2(TOTAL_PARAMS);
    localparam int INF_W        = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_PARAMS - 1);
    localparam logic [INF_W-1:0] MAX_INF  = INF_W'(MAX_INFLIGHT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DIGIT_WIDTH-1:0] fields_q [TOTAL_PARAMS];
    logic [INF_W-1:0]       inflight_q, inflight_d;
    logic                   underflow_q, underflow_d;
    logic                   desc_err_q, desc_err_d;

    logic                   desc_ready_s;
    logic                   accept_s;
    logic                   write_s;
    logic                   issue_s;
    logic                   zero_size_s;
    logic [DIGIT_WIDTH-1:0] instruc_d_s;

`ifdef LAYERIO_INSTRUC_VALIDATE_EN
    // Flag an offered descriptor whose size digits include a zero.
    always_comb begin
        zero_size_s = 1'b0;
        for (int i = 0; i < TOTAL_DIGITS; i++) begin
            if (bus.desc_sizes[i*DIGIT_WIDTH +: DIGIT_WIDTH] == '0) begin
                zero_size_s = 1'b1;
            end else begin
                zero_size_s = zero_size_s;
            end
        end
    end
`else
    assign zero_size_s = 1'b0;
`endif

    // FSM next state, field index and FIFO write strobe/data.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        desc_ready_s = 1'b0;
        accept_s     = 1'b0;
        write_s      = 1'b0;
        issue_s      = 1'b0;
        instruc_d_s  = '0;
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted so nothing is offered then.
                desc_ready_s = !reset && (inflight_q < MAX_INF);
                accept_s     = desc_ready_s && bus.desc_valid;
                if (accept_s && !zero_size_s) begin
                    state_d = SEND;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                write_s     = !bus.instruc_full;
                instruc_d_s = fields_q[idx_q];
                if (write_s) begin
                    if (idx_q == LAST_IDX) begin
                        issue_s = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Credit accounting: issue adds one, credit return removes one; a credit
    // with nothing outstanding is recorded as a sticky underflow instead.
    always_comb begin
        inflight_d  = inflight_q;
        underflow_d = underflow_q;
        desc_err_d  = accept_s && zero_size_s;
        case ({issue_s, bus.wrote_layerio_layer})
            2'b10: inflight_d = inflight_q + INF_W'(1);
            2'b01: begin
                if (inflight_q != '0) begin
                    inflight_d = inflight_q - INF_W'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end
            default: inflight_d = inflight_q;
        endcase
    end

    // State, index and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            inflight_q  <= '0;
            underflow_q <= 1'b0;
            desc_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            inflight_q  <= inflight_d;
            underflow_q <= underflow_d;
            desc_err_q  <= desc_err_d;
        end
    end

    // Capture the descriptor on accept; the inputs are not looked at again
    // until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TOTAL_PARAMS; i++) begin
                fields_q[i] <= '0;
            end
        end else if (accept_s) begin
            for (int i = 0; i < TOTAL_DIGITS; i++) begin
                fields_q[i]                <= bus.desc_sizes[i*DIGIT_WIDTH +: DIGIT_WIDTH];
                fields_q[TOTAL_DIGITS + i] <= bus.desc_strides[i*DIGIT_WIDTH +: DIGIT_WIDTH];
            end
            fields_q[2*TOTAL_DIGITS] <= bus.desc_offset;
        end
    end

    assign bus.desc_ready    = desc_ready_s;
    assign bus.instruc_wrreq = write_s;
    assign bus.instruc_d     = instruc_d_s;
    assign bus.issued_layer  = issue_s;
    assign bus.inflight      = inflight_q;
    assign bus.underflow_err = underflow_q;
    assign bus.desc_err      = desc_err_q;
endmodule
